// File: rtl/b8b10_pkg.sv
// Shared 8b/10b definitions: code tables, K/comma constants, RD and sync-state types.
// Used by both the b8b10 encoder and the b10b8 decoder.
package b8b10_pkg;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_t;

    typedef enum logic [1:0] {
        ST_LOS = 2'd0,
        ST_CD  = 2'd1,
        ST_ACQ = 2'd2
    } sync_state_t;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // abcdeif of K28.1/.5/.7; no other valid group carries these seven bits
    localparam logic [6:0] COMMA_RDN = K28_5_RDN[9:3];
    localparam logic [6:0] COMMA_RDP = K28_5_RDP[9:3];

    localparam logic [5:0] K28_6B_RDN = K28_5_RDN[9:4];
    localparam logic [5:0] K28_6B_RDP = K28_5_RDP[9:4];

    localparam logic [3:0] A7_RDN = 4'b0111;
    localparam logic [3:0] A7_RDP = 4'b1000;

    // 5b/6b (abcdei), indexed by EDCBA
    localparam logic [5:0] ENC6_RDN [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [5:0] ENC6_RDP [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100
    };

    // 3b/4b (fghj), indexed by HGF; entry 7 is the primary D.x.P7 form
    localparam logic [3:0] ENC4_RDN [0:7] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    localparam logic [3:0] ENC4_RDP [0:7] = '{
        4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001
    };

    typedef struct packed {
        logic       valid;
        logic [4:0] val;
    } dec6_t;

    typedef struct packed {
        logic       valid;
        logic       alt7;
        logic [2:0] val;
    } dec4_t;

    function automatic dec6_t decode_6b(input logic [5:0] code);
        dec6_t r;
        r.valid = 1'b0;
        r.val   = 5'd0;
        if (code == K28_6B_RDN || code == K28_6B_RDP) begin
            r.valid = 1'b1;
            r.val   = 5'd28;
        end
        for (int i = 0; i < 32; i++) begin
            if (code == ENC6_RDN[i] || code == ENC6_RDP[i]) begin
                r.valid = 1'b1;
                r.val   = 5'(i);
            end
        end
        return r;
    endfunction

    function automatic dec4_t decode_4b(input logic [3:0] code);
        dec4_t r;
        r.valid = 1'b0;
        r.alt7  = 1'b0;
        r.val   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (code == ENC4_RDN[i] || code == ENC4_RDP[i]) begin
                r.valid = 1'b1;
                r.val   = 3'(i);
            end
        end
        if (code == A7_RDN || code == A7_RDP) begin
            r.valid = 1'b1;
            r.alt7  = 1'b1;
            r.val   = 3'd7;
        end
        return r;
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/b10b8_sync_fsm.sv
// Comma-driven word-sync state machine with the bad-group and good-run counters.
// sync is decoded from the state register, so it lines up with the decoder's registered flags.
module b10b8_sync_fsm
    import b8b10_pkg::*;
#(
    parameter int SYNC_COMMAS = 3,
    parameter int LOSS_ERRS   = 4,
    parameter int GOOD_RUN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic comma,
    input  logic err,
    output logic sync
);

    localparam int CD_W = $clog2(SYNC_COMMAS + 1);
    localparam int BC_W = $clog2(LOSS_ERRS + 1);
    localparam int GC_W = $clog2(GOOD_RUN + 1);

    localparam logic [CD_W-1:0] CD_LAST = CD_W'(SYNC_COMMAS - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(LOSS_ERRS - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GOOD_RUN - 1);

    sync_state_t     state_reg, state_next;
    logic [CD_W-1:0] cd_reg, cd_next;
    logic [BC_W-1:0] bc_reg, bc_next;
    logic [GC_W-1:0] gc_reg, gc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_LOS;
            cd_reg    <= '0;
            bc_reg    <= '0;
            gc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cd_reg    <= cd_next;
            bc_reg    <= bc_next;
            gc_reg    <= gc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cd_next    = cd_reg;
        bc_next    = bc_reg;
        gc_next    = gc_reg;
        if (valid) begin
            case (state_reg)
                ST_LOS: begin
                    if (comma && !err) begin
                        if (SYNC_COMMAS <= 1) begin
                            state_next = ST_ACQ;
                            bc_next    = '0;
                            gc_next    = '0;
                        end else begin
                            state_next = ST_CD;
                            cd_next    = CD_W'(1);
                        end
                    end
                end
                ST_CD: begin
                    if (err) begin
                        state_next = ST_LOS;
                    end else if (comma) begin
                        if (cd_reg == CD_LAST) begin
                            state_next = ST_ACQ;
                            bc_next    = '0;
                            gc_next    = '0;
                        end else begin
                            cd_next = cd_reg + 1'b1;
                        end
                    end
                end
                ST_ACQ: begin
                    // An error breaks any good run in progress
                    if (err) begin
                        gc_next = '0;
                        if (bc_reg == BC_LAST) begin
                            state_next = ST_LOS;
                            bc_next    = '0;
                        end else begin
                            bc_next = bc_reg + 1'b1;
                        end
                    end else if (gc_reg == GC_LAST) begin
                        gc_next = '0;
                        if (bc_reg != '0) begin
                            bc_next = bc_reg - 1'b1;
                        end
                    end else begin
                        gc_next = gc_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_LOS;
                end
            endcase
        end
    end

    assign sync = (state_reg == ST_ACQ);

endmodule

// File: rtl/b10b8_decoder.sv
// Receive-side 8b/10b decoder: table lookup, per-sub-block RD check, comma detect, word sync.
// Optional B10B8_ERR_CNT_EN adds a saturating err_cnt output.
module b10b8_decoder
    import b8b10_pkg::*;
#(
    parameter int SYNC_COMMAS = 3,
    parameter int LOSS_ERRS   = 4,
`ifdef B10B8_ERR_CNT_EN
    parameter int CNT_W       = 16,
`endif
    parameter int GOOD_RUN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [9:0] in_code,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_k,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd_out,
    output logic       comma,
    output logic       sync
`ifdef B10B8_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic [5:0] code6;
    logic [3:0] code4;
    logic [3:0] code4_adj;
    dec6_t      d6;
    dec4_t      d4;
    logic [2:0] n6;
    logic [2:0] n4;
    logic       is_k28;
    logic       k_alt;
    logic       cerr_next;
    logic       derr6;
    logic       derr4;
    logic       derr_next;
    logic       k_next;
    logic       comma_next;
    logic       err_next;
    logic [7:0] data_next;
    rd_t        rd_reg, rd_mid, rd_next;

    logic       valid_reg;
    logic [7:0] data_reg;
    logic       k_reg;
    logic       cerr_reg;
    logic       derr_reg;
    logic       comma_reg;

    assign code6  = in_code[9:4];
    assign code4  = in_code[3:0];
    assign is_k28 = (code6 == K28_6B_RDN) || (code6 == K28_6B_RDP);

    // After 110000 the K28 4b codes are the complements of the data forms
    assign code4_adj = (code6 == K28_6B_RDP) ? ~code4 : code4;

    assign d6 = decode_6b(code6);
    assign d4 = decode_4b(code4_adj);

    assign k_alt = d6.valid && ((d6.val == 5'd23) || (d6.val == 5'd27) ||
                                (d6.val == 5'd29) || (d6.val == 5'd30));

    assign cerr_next  = !(d6.valid && d4.valid);
    assign k_next     = !cerr_next && (is_k28 || (k_alt && d4.alt7));
    assign data_next  = cerr_next ? 8'h00 : {d4.val, d6.val};
    assign comma_next = (in_code[9:3] == COMMA_RDN) || (in_code[9:3] == COMMA_RDP);

    always_comb begin
        n6      = ones6(code6);
        n4      = ones4(code4);
        derr6   = 1'b0;
        derr4   = 1'b0;
        rd_mid  = rd_reg;
        rd_next = rd_reg;

        if (code6 == 6'b000111) begin
            rd_mid = RD_POS;
        end else if (code6 == 6'b111000) begin
            rd_mid = RD_NEG;
        end else if (n6 > 3'd3) begin
            derr6  = (rd_reg == RD_POS);
            rd_mid = rd_t'(~rd_reg);
        end else if (n6 < 3'd3) begin
            derr6  = (rd_reg == RD_NEG);
            rd_mid = rd_t'(~rd_reg);
        end

        rd_next = rd_mid;
        if (code4 == 4'b0011) begin
            rd_next = RD_POS;
        end else if (code4 == 4'b1100) begin
            rd_next = RD_NEG;
        end else if (n4 > 3'd2) begin
            derr4   = (rd_mid == RD_POS);
            rd_next = rd_t'(~rd_mid);
        end else if (n4 < 3'd2) begin
            derr4   = (rd_mid == RD_NEG);
            rd_next = rd_t'(~rd_mid);
        end
    end

    assign derr_next = derr6 | derr4;
    assign err_next  = cerr_next | derr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= 8'h00;
            k_reg     <= 1'b0;
            cerr_reg  <= 1'b0;
            derr_reg  <= 1'b0;
            comma_reg <= 1'b0;
            rd_reg    <= RD_NEG;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg  <= data_next;
                k_reg     <= k_next;
                cerr_reg  <= cerr_next;
                derr_reg  <= derr_next;
                comma_reg <= comma_next;
                rd_reg    <= rd_next;
            end
        end
    end

    b10b8_sync_fsm #(
        .SYNC_COMMAS (SYNC_COMMAS),
        .LOSS_ERRS   (LOSS_ERRS),
        .GOOD_RUN    (GOOD_RUN)
    ) u_sync_fsm (
        .clk   (clk),
        .rst   (rst),
        .valid (in_valid),
        .comma (comma_next),
        .err   (err_next),
        .sync  (sync)
    );

`ifdef B10B8_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_reg <= '0;
        end else if (in_valid && err_next && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_k     = k_reg;
    assign code_err  = cerr_reg;
    assign disp_err  = derr_reg;
    assign rd_out    = rd_reg;
    assign comma     = comma_reg;

endmodule

// File: tb/tb_b10b8_decoder.sv
// Scoreboard bench for b10b8_decoder: directed code groups with hand-computed results.
module tb_b10b8_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] in_code;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_k;
    logic       code_err;
    logic       disp_err;
    logic       rd_out;
    logic       comma;
    logic       sync;
`ifdef B10B8_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    b10b8_decoder dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_k     (out_k),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .rd_out    (rd_out),
        .comma     (comma),
        .sync      (sync)
`ifdef B10B8_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct {
        int          id;
        logic [9:0]  code;
        logic [7:0]  data;
        logic        k;
        logic        ce;
        logic        de;
        logic        rd;
        logic        cm;
        logic        sy;
        logic [15:0] ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h required=%0h", name, id, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=out_valid required=no_output");
            end else begin
                mon_e = exp_q.pop_front();
                $display("vec %0d code=%b data=%02h k=%0b cerr=%0b derr=%0b rd=%0b comma=%0b sync=%0b",
                         mon_e.id, mon_e.code, out_data, out_k, code_err, disp_err, rd_out, comma, sync);
                chk("out_data", mon_e.id, {8'h00, out_data}, {8'h00, mon_e.data});
                chk("out_k",    mon_e.id, {15'd0, out_k},    {15'd0, mon_e.k});
                chk("code_err", mon_e.id, {15'd0, code_err}, {15'd0, mon_e.ce});
                chk("disp_err", mon_e.id, {15'd0, disp_err}, {15'd0, mon_e.de});
                chk("rd_out",   mon_e.id, {15'd0, rd_out},   {15'd0, mon_e.rd});
                chk("comma",    mon_e.id, {15'd0, comma},    {15'd0, mon_e.cm});
                chk("sync",     mon_e.id, {15'd0, sync},     {15'd0, mon_e.sy});
`ifdef B10B8_ERR_CNT_EN
                chk("err_cnt",  mon_e.id, err_cnt,           mon_e.ec);
`endif
            end
        end
    end

    task automatic send(input logic [9:0] code, input logic [7:0] data, input logic k,
                        input logic ce, input logic de, input logic rd, input logic cm,
                        input logic sy, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        vec_id++;
        e.id   = vec_id;
        e.code = code;
        e.data = data;
        e.k    = k;
        e.ce   = ce;
        e.de   = de;
        e.rd   = rd;
        e.cm   = cm;
        e.sy   = sy;
        e.ec   = ec;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", vec_id, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_out_valid"}, vec_id, {15'd0, out_valid}, 16'd0);
        chk({tag, "_out_data"},  vec_id, {8'h00, out_data},  16'd0);
        chk({tag, "_out_k"},     vec_id, {15'd0, out_k},     16'd0);
        chk({tag, "_code_err"},  vec_id, {15'd0, code_err},  16'd0);
        chk({tag, "_disp_err"},  vec_id, {15'd0, disp_err},  16'd0);
        chk({tag, "_rd_out"},    vec_id, {15'd0, rd_out},    16'd0);
        chk({tag, "_comma"},     vec_id, {15'd0, comma},     16'd0);
        chk({tag, "_sync"},      vec_id, {15'd0, sync},      16'd0);
`ifdef B10B8_ERR_CNT_EN
        chk({tag, "_err_cnt"},   vec_id, err_cnt,            16'd0);
`endif
    endtask

    localparam logic [9:0] K285N = 10'b0011111010;
    localparam logic [9:0] K285P = 10'b1100000101;
    localparam logic [9:0] D000  = 10'b1001110100;
    localparam logic [9:0] D215  = 10'b1010101010;
    localparam logic [9:0] ZERO  = 10'b0000000000;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 10'h000;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        //   code   data  k ce de rd cm sy  ec
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 0, 0);
        send(K285P, 8'hBC, 1, 0, 0, 0, 1, 0, 0);
        send(D000,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        send(D215,  8'hB5, 0, 0, 0, 0, 0, 0, 0);
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 1, 0);
        send(K285N, 8'hBC, 1, 0, 1, 0, 1, 1, 1);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 1, 2);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 1, 3);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 0, 4);
        drain();

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Acquire, then errors interleaved with good runs
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 0, 0);
        send(K285P, 8'hBC, 1, 0, 0, 0, 1, 0, 0);
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 1, 0);
        send(K285N, 8'hBC, 1, 0, 1, 0, 1, 1, 1);
        repeat (3) send(D215, 8'hB5, 0, 0, 0, 0, 0, 1, 1);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 1, 2);
        repeat (4) send(D215, 8'hB5, 0, 0, 0, 0, 0, 1, 2);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 1, 3);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 1, 4);
        send(D215,  8'hB5, 0, 0, 0, 0, 0, 1, 4);
        send(ZERO,  8'h00, 0, 1, 1, 0, 0, 0, 5);

        // An error during comma detection restarts the count
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 0, 5);
        send(ZERO,  8'h00, 0, 1, 1, 1, 0, 0, 6);
        send(K285P, 8'hBC, 1, 0, 0, 0, 1, 0, 6);
        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 0, 6);
        send(K285P, 8'hBC, 1, 0, 0, 0, 1, 1, 6);
        send(10'b1110101000, 8'hF7, 1, 0, 0, 0, 0, 1, 6);

        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_out_valid", vec_id, {15'd0, out_valid}, 16'd0);
        chk("hold_out_data",  vec_id, {8'h00, out_data},  16'h00F7);
        chk("hold_out_k",     vec_id, {15'd0, out_k},     16'd1);
        chk("hold_rd_out",    vec_id, {15'd0, rd_out},    16'd0);

        send(10'b1110100001, 8'hF7, 0, 0, 0, 0, 0, 1, 6);
        send(10'b1010101111, 8'h00, 0, 1, 0, 1, 0, 1, 7);

        // Reset lands while a group is on the input; it must never appear
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = K285N;
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        send(K285N, 8'hBC, 1, 0, 0, 1, 1, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
